cpu: RTL and testbench

- 32-bit MIPS-subset CPU with a classic 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
- Instruction and data memories are external:
  - instruction word arrives on i_datain every cycle;
  - load data arrives on d_datain;
  - store data and address leave on d_dataout / d_addr.
- No hazard detection, forwarding or flushing. Software (the bench) separates dependent instructions with 4 NOPs.

---
 rtl/cpu.sv | 170 +++++++++++++++++
 tb/tb_cpu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// 32-bit MIPS-subset CPU, 5-stage in-order pipeline (IF/ID/EX/MEM/WB), no hazard logic.
// Optional macro CPU_DWE_EN adds d_we, high while a sw is in MEM.
module cpu (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] i_datain,
   input  logic [31:0] d_datain,
   output logic [31:0] d_dataout,
   output logic [31:0] d_addr
`ifdef CPU_DWE_EN
   ,
   output logic        d_we
`endif
);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                          OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;

   logic [31:0] pc, instr;
   logic [31:0] gr [0:31];

   logic [31:0] id_pc_q;
   logic [31:0] ex_ir_q, ex_pc_q, ex_a_q, ex_b_q, ex_imm_q;
   logic [31:0] mem_res_q, mem_st_q;
   logic        mem_wen_q, mem_ld_q;
   logic [4:0]  mem_dest_q;
   logic [31:0] wb_val_q;
   logic        wb_wen_q;
   logic [4:0]  wb_dest_q;

   // ID: operand read and immediate extension
   logic [5:0]  id_op;
   logic [31:0] id_imm_d;
   assign id_op    = instr[31:26];
   assign id_imm_d = (id_op == OP_ANDI || id_op == OP_ORI) ? {16'h0, instr[15:0]}
                                                           : {{16{instr[15]}}, instr[15:0]};

   // EX: ALU and branch/jump resolution
   logic [5:0]  ex_op, ex_fn;
   logic [4:0]  ex_sh;
   logic [31:0] ex_pc4, ex_res_d, ex_tgt;
   logic        ex_wen_d, ex_ld_d, ex_redir;
   logic [4:0]  ex_dest_d;
   assign ex_op  = ex_ir_q[31:26];
   assign ex_fn  = ex_ir_q[5:0];
   assign ex_sh  = ex_ir_q[10:6];
   assign ex_pc4 = ex_pc_q + 32'd4;

   always_comb begin
      ex_res_d  = '0;
      ex_wen_d  = 1'b0;
      ex_ld_d   = 1'b0;
      ex_dest_d = '0;
      ex_redir  = 1'b0;
      ex_tgt    = ex_pc4;
      case (ex_op)
         OP_R: begin
            ex_wen_d  = 1'b1;
            ex_dest_d = ex_ir_q[15:11];
            case (ex_fn)
               6'h20, 6'h21: ex_res_d = ex_a_q + ex_b_q;
               6'h22, 6'h23: ex_res_d = ex_a_q - ex_b_q;
               6'h24: ex_res_d = ex_a_q & ex_b_q;
               6'h25: ex_res_d = ex_a_q | ex_b_q;
               6'h26: ex_res_d = ex_a_q ^ ex_b_q;
               6'h27: ex_res_d = ~(ex_a_q | ex_b_q);
               6'h2A: ex_res_d = {31'd0, $signed(ex_a_q) < $signed(ex_b_q)};
               6'h00: ex_res_d = ex_b_q << ex_sh;
               6'h02: ex_res_d = ex_b_q >> ex_sh;
               6'h03: ex_res_d = 32'($signed(ex_b_q) >>> ex_sh);
               6'h04: ex_res_d = ex_b_q << ex_a_q[4:0];
               6'h06: ex_res_d = ex_b_q >> ex_a_q[4:0];
               6'h07: ex_res_d = 32'($signed(ex_b_q) >>> ex_a_q[4:0]);
               6'h08: begin
                  ex_wen_d = 1'b0;
                  ex_redir = 1'b1;
                  ex_tgt   = ex_a_q;
               end
               default: ex_wen_d = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            ex_res_d  = ex_a_q + ex_imm_q;
            ex_wen_d  = 1'b1;
            ex_dest_d = ex_ir_q[20:16];
         end
         OP_ANDI, OP_ORI: begin
            ex_res_d  = (ex_op == OP_ANDI) ? (ex_a_q & ex_imm_q) : (ex_a_q | ex_imm_q);
            ex_wen_d  = 1'b1;
            ex_dest_d = ex_ir_q[20:16];
         end
         OP_LW: begin
            ex_res_d  = ex_a_q + ex_imm_q;
            ex_wen_d  = 1'b1;
            ex_ld_d   = 1'b1;
            ex_dest_d = ex_ir_q[20:16];
         end
         OP_SW: ex_res_d = ex_a_q + ex_imm_q;
         OP_BEQ, OP_BNE: begin
            ex_res_d = ex_a_q - ex_b_q;
            ex_redir = (ex_op == OP_BEQ) ? (ex_a_q == ex_b_q) : (ex_a_q != ex_b_q);
            ex_tgt   = ex_pc4 + {ex_imm_q[29:0], 2'b00};
         end
         OP_J, OP_JAL: begin
            ex_redir = 1'b1;
            ex_tgt   = {ex_pc4[31:28], ex_ir_q[25:0], 2'b00};
            if (ex_op == OP_JAL) begin
               ex_res_d  = ex_pc4;
               ex_wen_d  = 1'b1;
               ex_dest_d = 5'd31;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc         <= '0;
         instr      <= '0;
         id_pc_q    <= '0;
         ex_ir_q    <= '0;
         ex_pc_q    <= '0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_imm_q   <= '0;
         mem_res_q  <= '0;
         mem_st_q   <= '0;
         mem_wen_q  <= 1'b0;
         mem_ld_q   <= 1'b0;
         mem_dest_q <= '0;
         wb_val_q   <= '0;
         wb_wen_q   <= 1'b0;
         wb_dest_q  <= '0;
         for (int i = 0; i < 32; i++) gr[i] <= '0;
      end else if (start) begin
         pc         <= ex_redir ? ex_tgt : pc + 32'd4;
         instr      <= i_datain;
         id_pc_q    <= pc;
         ex_ir_q    <= instr;
         ex_pc_q    <= id_pc_q;
         ex_a_q     <= gr[instr[25:21]];
         ex_b_q     <= gr[instr[20:16]];
         ex_imm_q   <= id_imm_d;
         mem_res_q  <= ex_res_d;
         mem_st_q   <= ex_b_q;
         mem_wen_q  <= ex_wen_d;
         mem_ld_q   <= ex_ld_d;
         mem_dest_q <= ex_dest_d;
         wb_val_q   <= mem_ld_q ? d_datain : mem_res_q;
         wb_wen_q   <= mem_wen_q;
         wb_dest_q  <= mem_dest_q;
         // gr[0] is never written, so it keeps its reset value of zero
         if (wb_wen_q && wb_dest_q != 5'd0) gr[wb_dest_q] <= wb_val_q;
      end
   end

   assign d_addr    = mem_res_q;
   assign d_dataout = mem_st_q;

`ifdef CPU_DWE_EN
   logic mem_sw_q;
   always_ff @(posedge clock) begin
      if (reset)      mem_sw_q <= 1'b0;
      else if (start) mem_sw_q <= (ex_op == OP_SW);
   end
   assign d_we = mem_sw_q;
`endif
endmodule

// File: tb/tb_cpu.sv
// Directed-vector bench for cpu: each instruction is followed by 4 NOPs; a bench-side pc model tracks redirects.
module tb_cpu;
   logic        clock = 1'b0;
   logic        reset, start;
   logic [31:0] i_datain, d_datain, d_dataout, d_addr;
`ifdef CPU_DWE_EN
   logic        d_we;
`endif

   cpu dut (
      .clock(clock), .reset(reset), .start(start),
      .i_datain(i_datain), .d_datain(d_datain),
      .d_dataout(d_dataout), .d_addr(d_addr)
`ifdef CPU_DWE_EN
      , .d_we(d_we)
`endif
   );

   always #5 clock = ~clock;

   int          nvec = 0, nmis = 0;
   logic [31:0] mpc;
   logic [31:0] ex_pc, ex_addr, ex_dout, pci, tgt;
   logic        ex_we;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rt_(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction
   function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] jt_(input logic [5:0] op, input logic [25:0] t);
      return {op, t};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one instruction plus 4 NOPs; snapshot pc and MEM outputs right after its EX edge.
   task automatic run(input logic [31:0] w, input logic [31:0] din, input bit redir,
                      input logic [31:0] t);
      d_datain = din;
      for (int k = 0; k < 5; k++) begin
         i_datain = (k == 0) ? w : 32'h0;
         step();
         if (k == 2 && redir) mpc = t;
         else                 mpc = mpc + 32'd4;
         if (k == 2) begin
            ex_pc   = dut.pc;
            ex_addr = d_addr;
            ex_dout = d_dataout;
`ifdef CPU_DWE_EN
            ex_we   = d_we;
`else
            ex_we   = 1'b0;
`endif
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; i_datain = 32'hFFFF_FFFF; d_datain = '0;
      step(); step();
      reset = 1'b0; start = 1'b1; i_datain = '0; mpc = '0;
      chk("reset pc", dut.pc, 32'h0);
      chk("reset instr", dut.instr, 32'h0);
      chk("reset gr1", dut.gr[1], 32'h0);
      chk("reset d_addr", d_addr, 32'h0);
      chk("reset d_dataout", d_dataout, 32'h0);

      run(it_(6'h23, 0, 1, 16'd1), 32'h0000_00AB, 0, 0);
      chk("lw1 addr", ex_addr, 32'h1);
      chk("lw1 gr1", dut.gr[1], 32'h0000_00AB);
      run(it_(6'h23, 0, 2, 16'd2), 32'h0000_3C00, 0, 0);
      chk("lw2 gr2", dut.gr[2], 32'h0000_3C00);
      run(rt_(1, 2, 3, 0, 6'h20), 0, 0, 0);
      chk("add", dut.gr[3], 32'h3CAB);
      run(it_(6'h08, 3, 1, 16'd8), 0, 0, 0);
      chk("addi", dut.gr[1], 32'h3CB3);
      run(it_(6'h23, 0, 1, 16'd4), 32'h0000_3C09, 0, 0);
      run(rt_(1, 2, 3, 0, 6'h22), 0, 0, 0);
      chk("sub", dut.gr[3], 32'h9);
      run(rt_(2, 3, 1, 0, 6'h23), 0, 0, 0);
      chk("subu", dut.gr[1], 32'h3BF7);
      run(it_(6'h08, 0, 6, 16'hFFFF), 0, 0, 0);
      chk("addi sext", dut.gr[6], 32'hFFFF_FFFF);

      run(it_(6'h0C, 2, 1, 16'hE00F), 0, 0, 0);
      chk("andi", dut.gr[1], 32'h2000);
      run(it_(6'h0D, 2, 1, 16'hE01F), 0, 0, 0);
      chk("ori zext", dut.gr[1], 32'hFC1F);
      run(rt_(1, 2, 3, 0, 6'h27), 0, 0, 0);
      chk("nor", dut.gr[3], 32'hFFFF_03E0);
      run(rt_(1, 2, 3, 0, 6'h26), 0, 0, 0);
      chk("xor", dut.gr[3], 32'hC01F);

      run(rt_(0, 2, 3, 2, 6'h00), 0, 0, 0);
      chk("sll", dut.gr[3], 32'hF000);
      run(rt_(0, 2, 3, 2, 6'h03), 0, 0, 0);
      chk("sra", dut.gr[3], 32'h0F00);
      run(rt_(0, 1, 3, 3, 6'h02), 0, 0, 0);
      chk("srl", dut.gr[3], 32'h1F83);
      run(it_(6'h08, 0, 2, 16'd3), 0, 0, 0);
      run(rt_(2, 3, 1, 0, 6'h04), 0, 0, 0);
      chk("sllv", dut.gr[1], 32'hFC18);
      run(rt_(2, 3, 1, 0, 6'h06), 0, 0, 0);
      chk("srlv", dut.gr[1], 32'h03F0);
      run(rt_(3, 2, 1, 0, 6'h2A), 0, 0, 0);
      chk("slt false", dut.gr[1], 32'h0);
      run(it_(6'h23, 0, 5, 16'd0), 32'h8000_0000, 0, 0);
      run(rt_(5, 2, 4, 0, 6'h2A), 0, 0, 0);
      chk("slt signed", dut.gr[4], 32'h1);
      run(rt_(2, 5, 4, 0, 6'h07), 0, 0, 0);
      chk("srav", dut.gr[4], 32'hF000_0000);

      run(rt_(2, 0, 0, 0, 6'h08), 0, 1, 32'h3);
      chk("jr pc", ex_pc, 32'h3);
      run(jt_(6'h02, 26'h3FFF), 0, 1, 32'h0000_FFFC);
      chk("j pc", ex_pc, 32'h0000_FFFC);
      pci = mpc;
      tgt = {pci[31:28] + 4'h0, 26'h100, 2'b00};
      run(jt_(6'h03, 26'h100), 0, 1, tgt);
      chk("jal pc", ex_pc, 32'h400);
      chk("jal gr31", dut.gr[31], pci + 32'd4);
      pci = mpc;
      run(it_(6'h04, 0, 0, 16'd15), 0, 1, pci + 32'd4 + 32'h3C);
      chk("beq pc", ex_pc, pci + 32'd4 + 32'h3C);
      pci = mpc;
      run(it_(6'h05, 0, 0, 16'd15), 0, 0, 0);
      chk("bne pc", ex_pc, pci + 32'd12);
      chk("pc track", dut.pc, mpc);

      run(it_(6'h2B, 0, 3, 16'd15), 0, 0, 0);
      chk("sw addr", ex_addr, 32'hF);
      chk("sw data", ex_dout, 32'h1F83);
      chk("sw no write gr3", dut.gr[3], 32'h1F83);
`ifdef CPU_DWE_EN
      chk("sw d_we", {31'd0, ex_we}, 32'h1);
      chk("d_we idle", {31'd0, d_we}, 32'h0);
`endif
      run(it_(6'h08, 0, 0, 16'd5), 0, 0, 0);
      chk("gr0 zero", dut.gr[0], 32'h0);
      run(32'hFC21_0005, 0, 0, 0);
      chk("undef op", dut.gr[1], 32'h0);
      chk("undef pc", dut.pc, mpc);

      // freeze with an addi sitting in IF/ID
      i_datain = it_(6'h08, 0, 7, 16'h55);
      step(); mpc = mpc + 32'd4;
      start = 1'b0; i_datain = '0;
      for (int k = 0; k < 3; k++) step();
      chk("freeze pc", dut.pc, mpc);
      chk("freeze instr", dut.instr, it_(6'h08, 0, 7, 16'h55));
      chk("freeze gr7", dut.gr[7], 32'h0);
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin step(); mpc = mpc + 32'd4; end
      chk("resume gr7", dut.gr[7], 32'h55);
      chk("resume pc", dut.pc, mpc);

      // reset with a sw in flight
      i_datain = it_(6'h2B, 0, 3, 16'd15);
      step(); step();
      reset = 1'b1; i_datain = '0;
      step();
      reset = 1'b0;
      chk("mid reset pc", dut.pc, 32'h0);
      chk("mid reset gr3", dut.gr[3], 32'h0);
      chk("mid reset gr31", dut.gr[31], 32'h0);
      chk("mid reset gr7", dut.gr[7], 32'h0);
      step(); step();
      chk("mid reset d_addr", d_addr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
